dmem_wait_responder: RTL and testbench

Memory-side responder for the core's request/valid data-memory bus. It accepts one word-addressed load or store per transaction and applies per-byte write masks. It returns a single-cycle `valid` after a parameterised number of wait states. It sits on the far end of the core's data-memory port and gives the core a slow, stallable memory model for exercising its wait-on-valid logic and for deployment behind slower SRAM.

---
 rtl/dmem_wait_responder.sv | 136 +++++++++++++
 tb/tb_dmem_wait_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_wait_responder
//  Purpose  : Memory-side responder for a request/valid data-memory bus.
//             Accepts one word-addressed load or store at a time, applies
//             per-byte lane masks and answers with a one-cycle valid pulse
//             after WaitCycles wait states. DataWidth must be 32 (4 lanes).
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_wait_responder #(
    parameter int DataWidth  = 32,
    parameter int Address    = 8,
    parameter int WaitCycles = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 request,
    input  logic                 we_re,
    input  logic [3:0]           mask,
    input  logic [Address-1:0]   address,
    input  logic [DataWidth-1:0] data_in,
    output logic                 valid,
    output logic [DataWidth-1:0] data_out,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Counter preload; with no wait states WAIT is skipped so the value is unused.
    localparam logic [3:0] c_CNT_LOAD = 4'((WaitCycles > 0) ? (WaitCycles - 1) : 0);
    localparam int         c_DEPTH    = 1 << Address;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [3:0]             r_cnt;
    logic                   r_we;
    logic [3:0]             r_mask;
    logic [Address-1:0]     r_addr;
    logic [DataWidth-1:0]   r_data;
    logic                   r_valid;
    logic                   r_busy;
    logic [DataWidth-1:0]   r_data_out;
    logic [DataWidth-1:0]   r_mem [c_DEPTH];
    logic [DataWidth-1:0]   w_lane_mask;
    logic [DataWidth-1:0]   w_rd_word;
    logic [DataWidth-1:0]   w_wr_word;
    logic                   w_commit;

    // The transaction commits on the edge that leaves RESP, which is the same
    // edge that raises the registered valid, so data and valid appear together.
    assign w_commit  = (r_state == S_RESP);
    assign w_rd_word = r_mem[r_addr];
    assign w_wr_word = (w_rd_word & ~w_lane_mask) | (r_data & w_lane_mask);

    // Expand the latched 4-bit lane mask to a full-width bit mask.
    always_comb begin
        w_lane_mask = '0;
        for (int i = 0; i < 4; i++) begin
            w_lane_mask[8*i +: 8] = {8{r_mask[i]}};
        end
    end

    // Next-state logic: accept only in IDLE, count down in WAIT, one RESP cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (request) begin
                    w_state_next = (WaitCycles > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, wait counter and latched request fields; reset wins over request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_mask  <= 4'd0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && request) begin
                r_cnt  <= c_CNT_LOAD;
                r_we   <= we_re;
                r_mask <= mask;
                r_addr <= address;
                r_data <= data_in;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Registered outputs; load data is lane-masked and held until the next load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_valid <= w_commit;
            r_busy  <= (r_state != S_IDLE);
            if (w_commit && !r_we) begin
                r_data_out <= w_rd_word & w_lane_mask;
            end
        end
    end

    // Storage array: deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (rst && w_commit && r_we) begin
            r_mem[r_addr] <= w_wr_word;
        end
    end

    assign valid    = r_valid;
    assign busy     = r_busy;
    assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_dmem_wait_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_wait_responder
//  Purpose  : Directed self-checking bench for dmem_wait_responder, using a
//             WaitCycles=2 instance (a) and a WaitCycles=0 instance (z).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_wait_responder;

    logic        clk;
    logic        rst;
    logic        req_a, we_a, req_z, we_z;
    logic [3:0]  mask_a, mask_z;
    logic [7:0]  addr_a, addr_z;
    logic [31:0] din_a, din_z;
    logic        valid_a, busy_a, valid_z, busy_z;
    logic [31:0] dout_a, dout_z;

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_wait_responder #(.DataWidth(32), .Address(8), .WaitCycles(2)) u_dut_a (
        .clk(clk), .rst(rst), .request(req_a), .we_re(we_a), .mask(mask_a),
        .address(addr_a), .data_in(din_a), .valid(valid_a), .data_out(dout_a),
        .busy(busy_a)
    );

    dmem_wait_responder #(.DataWidth(32), .Address(8), .WaitCycles(0)) u_dut_z (
        .clk(clk), .rst(rst), .request(req_z), .we_re(we_z), .mask(mask_z),
        .address(addr_z), .data_in(din_z), .valid(valid_z), .data_out(dout_z),
        .busy(busy_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the request inputs of instance a (sel=0) or z (sel=1).
    task automatic drive(input bit sel, input logic rq, input logic we,
                         input logic [3:0] m, input logic [7:0] a, input logic [31:0] d);
        if (sel) begin
            req_z = rq; we_z = we; mask_z = m; addr_z = a; din_z = d;
        end else begin
            req_a = rq; we_a = we; mask_a = m; addr_a = a; din_a = d;
        end
    endtask

    // One full transaction with cycle-exact valid/busy checks; returns data seen with valid.
    task automatic xact(input bit sel, input logic we, input logic [3:0] m,
                        input logic [7:0] a, input logic [31:0] d, input string name,
                        output logic [31:0] rd);
        int   w;
        logic v, b;
        w  = sel ? 0 : 2;
        rd = 'x;
        @(negedge clk);
        drive(sel, 1'b1, we, m, a, d);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        for (int j = 0; j <= w + 3; j++) begin
            v = sel ? valid_z : valid_a;
            b = sel ? busy_z  : busy_a;
            n_cmp++;
            if (v !== (j == w + 1)) begin
                n_fail++;
                $display("FAIL %s valid cycle %0d: got %b expected %b", name, j, v, (j == w + 1));
            end
            n_cmp++;
            if (b !== (j >= 1 && j <= w + 1)) begin
                n_fail++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, j, b, (j >= 1 && j <= w + 1));
            end
            if (v === 1'b1) rd = sel ? dout_z : dout_a;
            @(negedge clk);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 4'hF, 8'h01, 32'hFFFFFFFF);
        drive(1'b1, 1'b1, 1'b1, 4'hF, 8'h01, 32'hFFFFFFFF);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset valid_a: got %b expected 0", valid_a); end
            n_cmp++; if (busy_a  !== 1'b0) begin n_fail++; $display("FAIL reset busy_a: got %b expected 0", busy_a); end
            check_word("reset dout_a", dout_a, 32'h0);
            n_cmp++; if (valid_z !== 1'b0) begin n_fail++; $display("FAIL reset valid_z: got %b expected 0", valid_z); end
            n_cmp++; if (busy_z  !== 1'b0) begin n_fail++; $display("FAIL reset busy_z: got %b expected 0", busy_z); end
            check_word("reset dout_z", dout_z, 32'h0);
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (busy_a !== 1'b0 || busy_z !== 1'b0) begin
                n_fail++;
                $display("FAIL reset no-accept busy: got %b/%b expected 0/0", busy_a, busy_z);
            end
        end
    endtask

    task automatic test_full_word();
        logic [31:0] rd;
        xact(1'b0, 1'b1, 4'hF, 8'h05, 32'hDEADBEEF, "store05", rd);
        xact(1'b0, 1'b0, 4'hF, 8'h05, 32'h0, "load05", rd);
        check_word("load05 data", rd, 32'hDEADBEEF);
    endtask

    task automatic test_byte_merge();
        logic [31:0] rd;
        xact(1'b0, 1'b1, 4'b0010, 8'h05, 32'h0000AA00, "store05 lane1", rd);
        check_word("dout held across store", dout_a, 32'hDEADBEEF);
        xact(1'b0, 1'b0, 4'hF, 8'h05, 32'h0, "merge load F", rd);
        check_word("merge load F data", rd, 32'hDEADAAEF);
        xact(1'b0, 1'b0, 4'b1100, 8'h05, 32'h0, "merge load C", rd);
        check_word("merge load C data", rd, 32'hDEAD0000);
        xact(1'b0, 1'b0, 4'b0000, 8'h05, 32'h0, "load mask0", rd);
        check_word("load mask0 data", rd, 32'h00000000);
        xact(1'b0, 1'b1, 4'b0000, 8'h05, 32'h12121212, "store mask0", rd);
        xact(1'b0, 1'b0, 4'hF, 8'h05, 32'h0, "load after mask0 store", rd);
        check_word("mask0 store no change", rd, 32'hDEADAAEF);
    endtask

    task automatic test_request_while_busy();
        logic [31:0] rd;
        int          pulses;
        pulses = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 4'hF, 8'h10, 32'h11111111);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 4'hF, 8'h10, 32'h22222222);
        for (int j = 0; j < 8; j++) begin
            if (j == 1) drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
            if (valid_a === 1'b1) pulses++;
            @(negedge clk);
        end
        n_cmp++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL busy-request pulses: got %0d expected 1", pulses);
        end
        xact(1'b0, 1'b0, 4'hF, 8'h10, 32'h0, "load10", rd);
        check_word("load10 data", rd, 32'h11111111);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int          pulses;
        pulses = 0;
        xact(1'b0, 1'b1, 4'hF, 8'h07, 32'h12345678, "store07 init", rd);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 4'hF, 8'h07, 32'hCAFEF00D);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if (valid_a === 1'b1) pulses++;
            @(negedge clk);
        end
        n_cmp++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset-mid valid pulses: got %0d expected 0", pulses);
        end
        xact(1'b0, 1'b0, 4'hF, 8'h07, 32'h0, "load07", rd);
        check_word("load07 data", rd, 32'h12345678);
    endtask

    task automatic test_boundary_w0();
        logic [31:0] rd;
        xact(1'b1, 1'b1, 4'hF, 8'hFF, 32'hA5A5A5A5, "w0 storeFF", rd);
        xact(1'b1, 1'b1, 4'hF, 8'h00, 32'h5A5A5A5A, "w0 store00", rd);
        xact(1'b1, 1'b0, 4'hF, 8'hFF, 32'h0, "w0 loadFF", rd);
        check_word("w0 loadFF data", rd, 32'hA5A5A5A5);
        xact(1'b1, 1'b0, 4'hF, 8'h00, 32'h0, "w0 load00", rd);
        check_word("w0 load00 data", rd, 32'h5A5A5A5A);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        test_reset();
        test_full_word();
        test_byte_merge();
        test_request_while_busy();
        test_reset_mid();
        test_boundary_w0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
